// File: rtl/simon_decrypt_core.sv
// Iterative SIMON32/64 decryption: expands the key schedule forward to k32..k35,
// then unwinds it one word at a time while applying inverse rounds.

module simon_dec_step (
  input  logic             inv,
  input  logic [4:0]       idx,
  input  logic [3:0][15:0] w_i,
  input  logic [15:0]      x_i,
  input  logic [15:0]      y_i,
  output logic [3:0][15:0] w_o,
  output logic [15:0]      x_o,
  output logic [15:0]      y_o
);
  localparam logic [61:0] Z0_SEQ = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [15:0] C = 16'hFFFC;

  logic        zb;
  logic [15:0] t3, tmp, kw, fy;

  // Forward window is k[i..i+3]; inverse window is k[i+1..i+4], so the tmp
  // taps shift down by one word in inverse mode.
  always_comb begin
    zb  = Z0_SEQ[6'd61 - {1'b0, idx}];
    t3  = inv ? w_i[2] : w_i[3];
    tmp = {t3[2:0], t3[15:3]} ^ (inv ? w_i[0] : w_i[1]);
    tmp = tmp ^ {tmp[0], tmp[15:1]};
    kw  = C ^ {15'b0, zb} ^ (inv ? w_i[3] : w_i[0]) ^ tmp;
    fy  = ({y_i[14:0], y_i[15]} & {y_i[7:0], y_i[15:8]}) ^ {y_i[13:0], y_i[15:14]};
    if (inv) begin
      w_o = {w_i[2], w_i[1], w_i[0], kw};
      x_o = y_i;
      y_o = x_i ^ fy ^ kw;
    end else begin
      w_o = {kw, w_i[3], w_i[2], w_i[1]};
      x_o = x_i;
      y_o = y_i;
    end
  end
endmodule

module simon_decrypt_core #(
  parameter int mixed_size = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] key_in,
  input  logic [31:0] cipher_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] plain_out
);
  localparam int N  = 32 / mixed_size;
  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0][15:0] kw_q, kw_d;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic [31:0]      plain_q, plain_d;

  logic                          inv;
  logic [4:0]                    base;
  logic [mixed_size:0][3:0][15:0] w_c;
  logic [mixed_size:0][15:0]      x_c, y_c;

  assign inv    = (state_q == DECRYPT);
  assign base   = 5'(int'(cnt_q) * mixed_size);
  assign w_c[0] = kw_q;
  assign x_c[0] = x_q;
  assign y_c[0] = y_q;

  for (genvar s = 0; s < mixed_size; s++) begin : g_step
    logic [4:0] idx_fwd, idx;
    assign idx_fwd = base + 5'(s);
    // Inverse order walks i = 31..0; 31 - v is ~v in 5 bits.
    assign idx     = inv ? ~idx_fwd : idx_fwd;
    simon_dec_step u_step (
      .inv(inv), .idx(idx),
      .w_i(w_c[s]),   .x_i(x_c[s]),   .y_i(y_c[s]),
      .w_o(w_c[s+1]), .x_o(x_c[s+1]), .y_o(y_c[s+1])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kw_d    = kw_q;
    x_d     = x_q;
    y_d     = y_q;
    plain_d = plain_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          kw_d    = key_in;
          x_d     = cipher_in[31:16];
          y_d     = cipher_in[15:0];
          cnt_d   = '0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        kw_d  = w_c[mixed_size];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DECRYPT;
        end
      end
      DECRYPT: begin
        // One extra cycle after the last round registers the result.
        if (cnt_q == CW'(N)) begin
          plain_d = {x_q, y_q};
          state_d = DONE;
        end else begin
          kw_d  = w_c[mixed_size];
          x_d   = x_c[mixed_size];
          y_d   = y_c[mixed_size];
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kw_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kw_q    <= kw_d;
      x_q     <= x_d;
      y_q     <= y_d;
      plain_q <= plain_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign plain_out = plain_q;
endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed bench for simon_decrypt_core (mixed_size=8) plus a random
// encrypt/decrypt round-trip sweep over mixed_size = 1, 4, 32.

module tb_simon_decrypt_core;
  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [63:0] key_in;
  logic [31:0] cipher_in, plain_out;

  logic              sw_valid, sw_oready;
  logic [63:0]       sw_key;
  logic [31:0]       sw_ct;
  logic [2:0]        sw_ir, sw_ov;
  logic [2:0][31:0]  sw_po;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [63:0] KV_KEY = 64'h1918111009080100;
  localparam logic [31:0] KV_CT  = 32'hC69BE9BB;
  localparam logic [31:0] KV_PT  = 32'h65656877;

  simon_decrypt_core #(.mixed_size(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .cipher_in(cipher_in), .out_valid(out_valid),
    .out_ready(out_ready), .plain_out(plain_out));

  simon_decrypt_core #(.mixed_size(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[0]),
    .key_in(sw_key), .cipher_in(sw_ct), .out_valid(sw_ov[0]),
    .out_ready(sw_oready), .plain_out(sw_po[0]));
  simon_decrypt_core #(.mixed_size(4)) u_s4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[1]),
    .key_in(sw_key), .cipher_in(sw_ct), .out_valid(sw_ov[1]),
    .out_ready(sw_oready), .plain_out(sw_po[1]));
  simon_decrypt_core #(.mixed_size(32)) u_s32 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_ir[2]),
    .key_in(sw_key), .cipher_in(sw_ct), .out_valid(sw_ov[2]),
    .out_ready(sw_oready), .plain_out(sw_po[2]));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  // Golden forward SIMON32/64 encryption.
  function automatic logic [31:0] simon_enc(input logic [63:0] key, input logic [31:0] pt);
    logic [61:0] z0s;
    logic [15:0] k [36];
    logic [15:0] tmp, x, y, t;
    z0s = 62'b11111010001001010110000111001101111101000100101011000011100110;
    for (int i = 0; i < 4; i++) k[i] = key[16*i +: 16];
    for (int i = 0; i < 28; i++) begin
      tmp = rr(k[i+3], 3) ^ k[i+1];
      tmp = tmp ^ rr(tmp, 1);
      k[i+4] = 16'hFFFC ^ {15'b0, z0s[61-i]} ^ k[i] ^ tmp;
    end
    x = pt[31:16];
    y = pt[15:0];
    for (int i = 0; i < 32; i++) begin
      t = x;
      x = y ^ ((rl(x, 1) & rl(x, 8)) ^ rl(x, 2)) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic start_job(input logic [63:0] k, input logic [31:0] c);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("start_ready", {63'b0, in_ready}, 64'd1);
    key_in = k; cipher_in = c; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  initial begin
    int lat, seen;
    int sw_lat [3];
    logic [31:0] sw_got [3];
    logic [2:0]  done;
    int lat_exp [3];
    logic [63:0] rk;
    logic [31:0] rpt, rct;
    lat_exp = '{65, 17, 3};

    rst = 1; in_valid = 0; out_ready = 1; key_in = '0; cipher_in = '0;
    sw_valid = 0; sw_oready = 1; sw_key = '0; sw_ct = '0;
    #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_plain", {32'b0, plain_out}, 64'd0);
    #21 rst = 0;
    @(negedge clk);
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // Known vector, consumer always ready
    start_job(KV_KEY, KV_CT);
    wait_out(lat);
    chk("kv_latency", 64'(lat), 64'd9);
    chk("kv_plain", {32'b0, plain_out}, {32'b0, KV_PT});
    @(posedge clk); #1;
    chk("kv_drop_valid", {63'b0, out_valid}, 64'd0);
    chk("kv_back_idle", {63'b0, in_ready}, 64'd1);

    // Backpressure
    out_ready = 0;
    start_job(KV_KEY, KV_CT);
    wait_out(lat);
    chk("bp_latency", 64'(lat), 64'd9);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {63'b0, out_valid}, 64'd1);
      chk("bp_plain", {32'b0, plain_out}, {32'b0, KV_PT});
      chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk("bp_release", {63'b0, out_valid}, 64'd0);

    // Reset while out_valid is held
    out_ready = 0;
    start_job(KV_KEY, KV_CT);
    wait_out(lat);
    #2 rst = 1; #1;
    chk("rst_done_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_done_plain", {32'b0, plain_out}, 64'd0);
    #2 rst = 0;
    out_ready = 1;

    // Inputs change and in_valid held during the job
    start_job(KV_KEY, KV_CT);
    key_in = '1; cipher_in = '1; in_valid = 1;
    wait_out(lat);
    chk("hold_latency", 64'(lat), 64'd9);
    chk("hold_plain", {32'b0, plain_out}, {32'b0, KV_PT});
    @(posedge clk); #1;
    chk("hold_idle_ready", {63'b0, in_ready}, 64'd1);
    @(posedge clk); #1;
    chk("hold_second_acc", {63'b0, in_ready}, 64'd0);
    in_valid = 0;
    wait_out(lat);
    chk("hold_second_lat", 64'(lat), 64'd9);

    // Reset pulse during DECRYPT aborts the job
    start_job(KV_KEY, KV_CT);
    repeat (6) @(posedge clk);
    #2 rst = 1; #1;
    chk("abort_valid", {63'b0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'b0, in_ready}, 64'd0);
    #1 rst = 0;
    seen = 0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("abort_no_output", 64'(seen), 64'd0);
    start_job(KV_KEY, KV_CT);
    wait_out(lat);
    chk("abort_next_lat", 64'(lat), 64'd9);
    chk("abort_next_plain", {32'b0, plain_out}, {32'b0, KV_PT});

    // Round-trip sweep across mixed_size = 1, 4, 32
    for (int v = 0; v < 300; v++) begin
      rk  = {$urandom, $urandom};
      rpt = $urandom;
      if (v == 0) rk = KV_KEY;
      if (v == 0) rpt = KV_PT;
      rct = simon_enc(rk, rpt);
      if (v == 0) chk("golden_kv", {32'b0, rct}, {32'b0, KV_CT});
      @(negedge clk);
      for (int n = 0; n < 100 && sw_ir != 3'b111; n++) @(negedge clk);
      sw_key = rk; sw_ct = rct; sw_valid = 1;
      @(posedge clk); #1;
      sw_valid = 0;
      done = '0;
      for (int j = 0; j < 3; j++) begin sw_lat[j] = 0; sw_got[j] = '0; end
      for (int c = 1; c <= 100 && done != 3'b111; c++) begin
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++)
          if (!done[j] && sw_ov[j]) begin
            done[j] = 1; sw_lat[j] = c; sw_got[j] = sw_po[j];
          end
      end
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("sweep%0d_plain", j), {32'b0, sw_got[j]}, {32'b0, rpt});
        chk($sformatf("sweep%0d_lat", j), 64'(sw_lat[j]), 64'(lat_exp[j]));
      end
      @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
